// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, SR/Cause field layout.
package cp0_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IE_BIT    = 0;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
    logic [31:0] v;
    v = 32'h0;
    v[SR_IM_HI:SR_IM_LO] = im;
    v[SR_EXL_BIT]        = exl;
    v[SR_IE_BIT]         = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
    logic [31:0] v;
    v = 32'h0;
    v[CAUSE_BD_BIT]              = bd;
    v[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 controller: SR/Cause/EPC/PRId, interrupt/exception arbitration and pipeline flush request.
// Optional BadVAddr register (address 8) is enabled by defining CP0_BADVADDR_EN.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2001_0507
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadVAddrIn,
`endif
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im_r;
  logic        sr_exl_r;
  logic        sr_ie_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_r;
  logic        addr_exc_s;
`endif

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic [31:0] dout_s;

  // Request arbitration; EXL masks both sources so exceptions never nest.
  always_comb begin
    int_req_s = (|(HWInt & sr_im_r)) & sr_ie_r & ~sr_exl_r;
    exc_req_s = (ExcCode != 5'd0) & ~sr_exl_r;
    req_s     = int_req_s | exc_req_s;
  end

`ifdef CP0_BADVADDR_EN
  assign addr_exc_s = (ExcCode == EXC_ADEL) || (ExcCode == EXC_ADES);
`endif

  // Register update: reset, then exception entry, then mtc0 / eret.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_r     <= 6'd0;
      sr_exl_r    <= 1'b0;
      sr_ie_r     <= 1'b0;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= 32'h0;
`ifdef CP0_BADVADDR_EN
      badvaddr_r  <= 32'h0;
`endif
    end else begin
      cause_ip_r <= HWInt;
      if (req_s) begin
        sr_exl_r    <= 1'b1;
        cause_bd_r  <= BD;
        cause_exc_r <= int_req_s ? EXC_INT : ExcCode;
        epc_r       <= BD ? (PC - 32'd4) : PC;
`ifdef CP0_BADVADDR_EN
        if (!int_req_s && addr_exc_s) begin
          badvaddr_r <= BadVAddrIn;
        end
`endif
      end else begin
        if (WE) begin
          case (A2)
            ADDR_SR: begin
              sr_im_r  <= DIn[SR_IM_HI:SR_IM_LO];
              sr_exl_r <= DIn[SR_EXL_BIT];
              sr_ie_r  <= DIn[SR_IE_BIT];
            end
            ADDR_EPC: epc_r <= DIn;
            default: ;
          endcase
        end
        // eret clears EXL even if a same-edge mtc0 to SR tried to set it.
        if (EXLClr) begin
          sr_exl_r <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux; unmapped addresses read zero.
  always_comb begin
    dout_s = 32'h0;
    case (A1)
      ADDR_SR:       dout_s = pack_sr(sr_im_r, sr_exl_r, sr_ie_r);
      ADDR_CAUSE:    dout_s = pack_cause(cause_bd_r, cause_ip_r, cause_exc_r);
      ADDR_EPC:      dout_s = epc_r;
      ADDR_PRID:     dout_s = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
      ADDR_BADVADDR: dout_s = badvaddr_r;
`endif
      default:       dout_s = 32'h0;
    endcase
  end

  assign Req    = req_s;
  assign EPCOut = epc_r;
  assign DOut   = dout_s;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: stimulus queues expected outputs, a negedge monitor compares them.
module tb_cp0_ctrl;

  localparam int K_REQ  = 0;
  localparam int K_DOUT = 1;
  localparam int K_EPC  = 2;
`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] BADV_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] BADV_EXP = 32'h0000_0000;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
`ifdef CP0_BADVADDR_EN
  logic [31:0] BadVAddrIn;
`endif
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  exp_t exp_q[$];
  int   cycle_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  cp0_ctrl dut (
    .clk(clk),
    .reset(reset),
    .A1(A1),
    .A2(A2),
    .DIn(DIn),
    .WE(WE),
    .PC(PC),
    .BD(BD),
    .ExcCode(ExcCode),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
`ifdef CP0_BADVADDR_EN
    .BadVAddrIn(BadVAddrIn),
`endif
    .Req(Req),
    .EPCOut(EPCOut),
    .DOut(DOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cycle_cnt;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    A1 = a;
    expect_out(K_DOUT, v, nm);
  endtask

  // Monitor: drains expectations due this cycle and compares them with live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
        e = exp_q.pop_front();
        checks++;
        case (e.kind)
          K_REQ:   act = {31'h0, Req};
          K_DOUT:  act = DOut;
          default: act = EPCOut;
        endcase
        if (e.cyc != cycle_cnt) begin
          errors++;
          $display("FAIL %s: expectation from cycle %0d not sampled in time", e.name, e.cyc);
        end else if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: actual %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0;
    PC = 32'h0; BD = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
`ifdef CP0_BADVADDR_EN
    BadVAddrIn = 32'h0;
`endif
    cyc(); cyc();
    // Reset state
    reset = 1'b0;
    rd(5'd12, 32'h0, "rst_sr"); expect_out(K_REQ, 32'h0, "rst_req");
    cyc(); rd(5'd13, 32'h0, "rst_cause");
    cyc(); rd(5'd14, 32'h0, "rst_epc");
    cyc(); rd(5'd15, 32'h2001_0507, "prid");
    cyc(); rd(5'd5, 32'h0, "unmapped");

    // Interrupt entry
    cyc(); WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; rd(5'd12, 32'h0, "sr_before_wr");
    cyc(); WE = 1'b0; HWInt = 6'b000001; PC = 32'h3010; BD = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_wr"); expect_out(K_REQ, 32'h1, "int_req");
    cyc(); rd(5'd14, 32'h3010, "int_epc"); expect_out(K_EPC, 32'h3010, "int_epcout");
    expect_out(K_REQ, 32'h0, "int_exl_mask");
    cyc(); rd(5'd12, 32'h0000_0403, "int_sr_exl");
    cyc(); rd(5'd13, 32'h0000_0400, "int_cause");
    cyc(); HWInt = 6'd0; EXLClr = 1'b1; expect_out(K_REQ, 32'h0, "eret_req");
    cyc(); EXLClr = 1'b0; rd(5'd12, 32'h0000_0401, "eret_sr");
    expect_out(K_REQ, 32'h0, "idle_req");

    // Overflow in delay slot with IE=0
    cyc(); WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    cyc(); WE = 1'b0; ExcCode = 5'd12; PC = 32'h3024; BD = 1'b1;
    expect_out(K_REQ, 32'h1, "ov_req");
    cyc(); ExcCode = 5'd0; BD = 1'b0; rd(5'd13, 32'h8000_0030, "ov_cause");
    expect_out(K_EPC, 32'h3020, "ov_epc");
    cyc(); rd(5'd12, 32'h0000_0002, "ov_sr"); EXLClr = 1'b1;
    cyc(); EXLClr = 1'b0; rd(5'd12, 32'h0, "ov_eret_sr");

    // Same-edge mtc0 EPC with RI exception
    cyc(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234; ExcCode = 5'd10; PC = 32'h3040;
    expect_out(K_REQ, 32'h1, "ri_req");
    cyc(); WE = 1'b0; ExcCode = 5'd0; rd(5'd14, 32'h3040, "ri_epc_wins");
    expect_out(K_EPC, 32'h3040, "ri_epcout");
    cyc(); rd(5'd13, 32'h0000_0028, "ri_cause"); EXLClr = 1'b1;
    cyc(); EXLClr = 1'b0; WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
    expect_out(K_EPC, 32'h3040, "epc_no_bypass");
    cyc(); A2 = 5'd13; DIn = 32'hFFFF_FFFF; rd(5'd14, 32'h0000_1234, "epc_mtc0");
    cyc(); WE = 1'b0; rd(5'd13, 32'h0000_0028, "cause_ro");

    // EXL blocks requests; eret releases them with interrupt priority
    cyc(); WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
    cyc(); WE = 1'b0; ExcCode = 5'd4; HWInt = 6'h3F; PC = 32'h3060;
    rd(5'd12, 32'h0000_FC03, "exl_sr"); expect_out(K_REQ, 32'h0, "exl_block");
    cyc(); EXLClr = 1'b1; expect_out(K_REQ, 32'h0, "exl_block_eret");
    cyc(); EXLClr = 1'b0; rd(5'd12, 32'h0000_FC01, "eret_sr2");
    expect_out(K_REQ, 32'h1, "eret_req_int");
    cyc(); ExcCode = 5'd0; HWInt = 6'd0; rd(5'd13, 32'h0000_FC00, "int_prio_cause");
    expect_out(K_EPC, 32'h3060, "int_prio_epc"); expect_out(K_REQ, 32'h0, "int_prio_exl");
    cyc(); rd(5'd8, 32'h0, "badv_int_prio");

    // Reset while EXL=1
    cyc(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3050;
    cyc(); WE = 1'b0; rd(5'd14, 32'h3050, "pre_rst_epc");
    reset = 1'b1; HWInt = 6'h3F; ExcCode = 5'd12;
    cyc(); reset = 1'b0; HWInt = 6'd0; ExcCode = 5'd0;
    rd(5'd12, 32'h0, "rst2_sr"); expect_out(K_REQ, 32'h0, "rst2_req");
    expect_out(K_EPC, 32'h0, "rst2_epcout");
    cyc(); rd(5'd13, 32'h0, "rst2_cause");
    cyc(); rd(5'd14, 32'h0, "rst2_epc");
    cyc(); HWInt = 6'h3F; expect_out(K_REQ, 32'h0, "rst_ie_mask");

    // Address error load
    cyc(); HWInt = 6'd0; ExcCode = 5'd4; PC = 32'h3070;
`ifdef CP0_BADVADDR_EN
    BadVAddrIn = 32'h0000_0003;
`endif
    expect_out(K_REQ, 32'h1, "adel_req");
    cyc(); ExcCode = 5'd0; rd(5'd8, BADV_EXP, "badv_read");
    expect_out(K_EPC, 32'h3070, "adel_epc");
    cyc(); rd(5'd13, 32'h0000_0010, "adel_cause");
    WE = 1'b1; A2 = 5'd8; DIn = 32'hFFFF_FFFF;
    cyc(); WE = 1'b0; rd(5'd8, BADV_EXP, "badv_ro");

    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have parameter PRID_VALUE, default 32'h2001_0507, constant returned on reads of register 15 (PRId).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- A1  in  5  CP0 read address (mfc0).
- A2  in  5  CP0 write address (mtc0).
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the M-stage instruction.
- BD  in  1  M-stage instruction is in a delay slot.
- ExcCode  in  5  M-stage exception code; 0 means none.
- HWInt  in  6  external interrupt lines.
- EXLClr  in  1  eret in M; clear EXL.
- Req  out  1  flush request to all pipeline registers.
- EPCOut  out  32  current EPC value, for eret redirect.
- DOut  out  32  mfc0 read data.

Function
REQ-003 SHALL implement register SR (12) with fields IM[15:10], EXL[1] and IE[0]; all other bits read 0.
REQ-004 SHALL implement register Cause (13) with fields BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0.
REQ-005 SHALL capture IP from HWInt on every clock edge, regardless of EXL and of Req.
REQ-006 SHALL implement register EPC (14) as a 32-bit register and PRId (15) as read-only PRID_VALUE.
REQ-007 SHALL drive DOut combinationally from A1; unmapped addresses and write-only state SHALL read 32'h0.
REQ-008 SHALL compute IntReq = (|(HWInt & SR.IM)) & SR.IE & !SR.EXL, combinationally.
REQ-009 SHALL compute ExcReq = (ExcCode != 0) & !SR.EXL, combinationally.
REQ-010 SHALL drive Req = IntReq | ExcReq combinationally, in the same cycle as its cause, with zero latency.
REQ-011 SHALL, on an edge where Req=1, perform all of the following:
- set EXL to 1;
- set Cause.BD to BD;
- set Cause.ExcCode to 0 if IntReq, else to ExcCode;
- set EPC to PC-4 if BD, else to PC.
REQ-012 SHALL give the interrupt priority over a simultaneous synchronous exception.
REQ-013 SHALL, on an edge where WE=1 and Req=0, write DIn to the writable fields of A2: SR.IM, SR.EXL, SR.IE or the full EPC; writes to Cause, PRId or unmapped addresses SHALL be ignored.
REQ-014 SHALL, when Req=1 and WE=1 on the same edge, discard the mtc0 write and let the Req update win.
REQ-015 SHALL, on an edge where EXLClr=1 and Req=0, clear EXL.
- EXLClr with Req=1 cannot occur, because Req requires EXL=0; if it does, Req wins.
REQ-016 SHALL drive EPCOut directly from the EPC register, with no bypass of a same-cycle mtc0.
REQ-017 SHALL keep Req=0 while EXL=1, whatever ExcCode and HWInt are (no nested exceptions).

Reset
REQ-018 SHALL, on an edge with reset=1, clear SR, Cause, EPC and (if present) BadVAddr to 0.
REQ-019 SHALL give reset priority over Req, WE and EXLClr.
REQ-020 SHALL hold Req=0 in the cycle following reset until HWInt/ExcCode qualify under the cleared SR (IE=0 masks all interrupts).

Configuration
REQ-021 SHALL, with macro CP0_BADVADDR_EN defined:
- add input BadVAddrIn (32);
- add register BadVAddr (8), loaded from BadVAddrIn on a Req edge where ExcCode is 4 (AdEL) or 5 (AdES) and IntReq=0;
- make BadVAddr readable via DOut and not writable by mtc0.
REQ-022 SHALL, without CP0_BADVADDR_EN, omit the BadVAddrIn port and the register, and read address 8 as 0.

Structure
REQ-023 SHALL take the following from shared package cp0_pkg:
- register address constants (8, 12, 13, 14, 15);
- ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
- SR and Cause field bit positions.
REQ-024 SHALL implement arbitration inline with no sub-module; the pipeline stage registers consume Req as their flush input.

Verification
REQ-025 SHALL pass each directed scenario below:
- Sequence SR=32'h0000_0401 via mtc0, then HWInt=6'b000001 with PC=32'h3010 and BD=0. Required: Req=1 that cycle; next cycle EPC=32'h3010, Cause.ExcCode=0, EXL=1, Req=0.
- ExcCode=12 with PC=32'h3024, BD=1 and SR.IE=0. Required: Req=1; EPC=32'h3020, Cause=32'h8000_0030.
- Same-edge mtc0 to EPC (DIn=32'h1234) with ExcCode=10. Required: EPC=PC, not 32'h1234.
- With EXL=1, assert ExcCode=4 and HWInt=6'h3F. Required: Req stays 0. Then assert EXLClr. Required: EXL=0 next cycle and Req=1 with interrupt priority.
- Reset while EXL=1 and EPC=32'h3050. Required: next cycle DOut=0 for A1=12, 13 and 14, and Req=0.
- With CP0_BADVADDR_EN defined, ExcCode=4 and BadVAddrIn=32'h0000_0003. Required: A1=8 reads 32'h3. Without the macro, A1=8 reads 0.
